program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream run sequencer for the single-cycle core.
- Receives a program as a byte stream and writes it into instruction memory through a write port.
- Holds the core in reset during load, then releases it and counts cycles until the core raises done.
- Reports completion, cycle count and error to the testbench/host side.

Parameters:
INSTR_W, 9, instruction word width in bits (9..16)
CYC_W, 16, cycle counter width
RST_CYC, 2, cycles the core's reset stays high after the last instruction write (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a load/run session; sampled only in IDLE or DONE
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  byte-stream ready; a byte transfers on in_valid & in_ready at a rising edge
im_we  output  1  instruction memory write enable, one-cycle pulse
im_addr  output  8  instruction memory write address
im_wdata  output  INSTR_W  instruction memory write data
cpu_reset  output  1  drives the core's reset input
cpu_done  input  1  core's done/halt output
busy  output  1  high in any state except IDLE and DONE
finished  output  1  high in DONE
cycles  output  CYC_W  core run cycle count, frozen in DONE
err  output  1  sticky error for the session: zero length or counter saturation

Behaviour:
- Reset (async, any state): state=IDLE, cpu_reset=1, all other outputs 0, internal index/length/low-byte registers 0.
- All outputs are registered, except in_ready, busy, finished and cpu_reset, which are decoded from state.
- States: IDLE, LEN, LO, HI, RST, RUN, DONE.
- IDLE:
  - in_ready=0, cpu_reset=1.
  - start=1 -> LEN.
- LEN:
  - in_ready=1.
  - On transfer: N=in_data, index=0.
  - N==0 -> DONE with err=1, cycles=0.
  - Otherwise -> LO.
- LO:
  - in_ready=1.
  - On transfer: capture the low byte -> HI.
- HI:
  - in_ready=1.
  - On transfer, the next cycle has im_we=1, im_addr=index, im_wdata={in_data[INSTR_W-9:0], low byte}.
  - Upper in_data bits beyond INSTR_W-8 are ignored.
  - If index==N-1 -> RST; otherwise index+=1 -> LO.
- im_we is high for exactly one cycle per instruction; im_addr/im_wdata hold their last values otherwise.
- in_valid may drop at any time in LEN/LO/HI; the state waits with no side effects.
- RST:
  - in_ready=0, cpu_reset=1 for RST_CYC cycles (counted from RST entry).
  - Then -> RUN with cycles=0.
- RUN:
  - cpu_reset=0, in_ready=0.
  - Each clock edge in RUN with cpu_done=0: cycles+=1.
  - At the first edge with cpu_done=1: -> DONE, cycles unchanged, so cycles = number of RUN edges before done was sampled.
  - cycles reaching all-ones with cpu_done still 0 -> DONE with err=1, cycles=all-ones (saturates, no wrap).
  - cpu_done is ignored outside RUN.
- DONE:
  - finished=1, cpu_reset=0 (core state stays inspectable), in_ready=0.
  - start=1 -> LEN: on that same edge clear err, cycles and finished.
- start is ignored in LEN/LO/HI/RST/RUN.
- Reset mid-session aborts immediately to IDLE. Instruction memory contents already written are left as-is.

Test Plan:
- Load 3 instructions, bytes 03,12,01,34,00,FF,01 sent back-to-back, core done after 5 RUN cycles -> im_we pulses at addr 0,1,2 with data 0x112,0x034,0x1FF. cpu_reset is high through RST_CYC=2 cycles, then low. finished=1, cycles=5, err=0.
- Same stream with in_valid deasserted for 3 cycles between every byte -> identical writes and results; no extra im_we pulses.
- Length byte 00 -> DONE next edge, err=1, cycles=0, no im_we, cpu_reset never deasserted before DONE.
- CYC_W=4, cpu_done held 0 -> DONE after 15 RUN edges, cycles=15, err=1.
- Reset asserted after the 2nd instruction byte -> state IDLE asynchronously, cpu_reset=1, busy=0, in_ready=0; a following full session completes normally.
- From DONE with err=1, start pulse plus a 1-instruction stream, core done after 1 cycle -> err cleared, cycles=1, finished=1.

Source files
------------

// File: rtl/program_loader.sv
// Loads a byte-stream program into instruction memory, holds the core in reset
// during the load, then runs it and counts cycles until the core signals done.
module program_loader #(
  parameter int INSTR_W = 9,
  parameter int CYC_W   = 16,
  parameter int RST_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               im_we,
  output logic [7:0]         im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_reset,
  input  logic               cpu_done,
  output logic               busy,
  output logic               finished,
  output logic [CYC_W-1:0]   cycles,
  output logic               err
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0]   RCNT_LAST = RCW'(RST_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_LO, S_HI, S_RST, S_RUN, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         n_q, n_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         lo_q, lo_d;
  logic [RCW-1:0]     rcnt_q, rcnt_d;
  logic               we_q, we_d;
  logic [7:0]         addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               err_q, err_d;
  logic               xfer;

  assign in_ready  = (state_q == S_LEN) || (state_q == S_LO) || (state_q == S_HI);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign finished  = (state_q == S_DONE);
  // The core stays out of reset in DONE so its state can be inspected.
  assign cpu_reset = (state_q != S_RUN) && (state_q != S_DONE);
  assign xfer      = in_valid && in_ready;

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign cycles   = cyc_q;
  assign err      = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      rcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      rcnt_q  <= rcnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    rcnt_d  = rcnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEN;
          cyc_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          n_d   = in_data;
          idx_d = '0;
          if (in_data == 8'd0) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            cyc_d   = '0;
          end else begin
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = {in_data[INSTR_W-9:0], lo_q};
          if (idx_q == n_q - 8'd1) begin
            state_d = S_RST;
            rcnt_d  = '0;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_LO;
          end
        end
      end
      S_RST: begin
        if (rcnt_q == RCNT_LAST) begin
          state_d = S_RUN;
          cyc_d   = '0;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      S_RUN: begin
        // Saturate rather than wrap; a runaway core ends the session with err.
        if (cpu_done) begin
          state_d = S_DONE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
          if (cyc_d == CYC_MAX) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: full loads, stalled stream, zero length,
// counter saturation (CYC_W=4 instance), mid-session reset and error clearing.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, in_valid, cpu_done;
  logic [7:0] in_data;
  logic       in_ready, im_we, cpu_reset, busy, finished, err;
  logic [7:0] im_addr;
  logic [8:0] im_wdata;
  logic [15:0] cycles;

  logic       start4, in_valid4, cpu_done4;
  logic [7:0] in_data4;
  logic       in_ready4, im_we4, cpu_reset4, busy4, finished4, err4;
  logic [7:0] im_addr4;
  logic [8:0] im_wdata4;
  logic [3:0] cycles4;

  always #5 clk = ~clk;

  program_loader #(.INSTR_W(9), .CYC_W(16), .RST_CYC(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_reset(cpu_reset), .cpu_done(cpu_done), .busy(busy), .finished(finished),
    .cycles(cycles), .err(err)
  );

  program_loader #(.INSTR_W(9), .CYC_W(4), .RST_CYC(2)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(in_ready4), .im_we(im_we4), .im_addr(im_addr4), .im_wdata(im_wdata4),
    .cpu_reset(cpu_reset4), .cpu_done(cpu_done4), .busy(busy4), .finished(finished4),
    .cycles(cycles4), .err(err4)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] wr_a [64];
  logic [8:0] wr_d [64];
  int wr_n = 0, rst_n = 0, run_n = 0, run4_n = 0;
  int wb, rb, ub;
  logic [7:0] stim [8];

  always @(negedge clk) begin
    if (im_we && wr_n < 64) begin
      wr_a[wr_n] = im_addr;
      wr_d[wr_n] = im_wdata;
      wr_n++;
    end
    if (busy && cpu_reset && !in_ready) rst_n++;
    if (busy && !cpu_reset) run_n++;
    if (busy4 && !cpu_reset4) run4_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_session(input int nb, input int gap, input int done_after, input bit hold_done);
    int k;
    wb = wr_n; rb = rst_n; ub = run_n;
    do_start();
    chk("start_err_clr", 32'(err), 32'd0);
    chk("start_cyc_clr", 32'(cycles), 32'd0);
    if (hold_done) cpu_done = 1'b1;
    for (int i = 0; i < nb; i++) begin
      send_byte(stim[i]);
      if (gap > 0 && i < nb - 1) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    cpu_done = 1'b0;
    k = 0;
    @(negedge clk);
    while (!finished && cpu_reset && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait_run", 32'(finished | !cpu_reset), 32'd1);
    if (!finished) begin
      repeat (done_after) @(posedge clk);
      #1 cpu_done = 1'b1;
      @(posedge clk); #1;
      cpu_done = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_three();
    chk("nwr", 32'(wr_n - wb), 32'd3);
    chk("addr0", 32'(wr_a[wb]),   32'h00);
    chk("data0", 32'(wr_d[wb]),   32'h112);
    chk("addr1", 32'(wr_a[wb+1]), 32'h01);
    chk("data1", 32'(wr_d[wb+1]), 32'h034);
    chk("addr2", 32'(wr_a[wb+2]), 32'h02);
    chk("data2", 32'(wr_d[wb+2]), 32'h1FF);
    chk("rst_cycles", 32'(rst_n - rb), 32'd2);
    chk("finished", 32'(finished), 32'd1);
    chk("cycles5", 32'(cycles), 32'd5);
    chk("err0", 32'(err), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
    chk("cpu_reset_done", 32'(cpu_reset), 32'd0);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; cpu_done = 1'b0;
    start4 = 1'b0; in_valid4 = 1'b0; in_data4 = 8'h00; cpu_done4 = 1'b0;
    stim[0] = 8'h03; stim[1] = 8'h12; stim[2] = 8'h01; stim[3] = 8'h34;
    stim[4] = 8'h00; stim[5] = 8'hFF; stim[6] = 8'h01; stim[7] = 8'h00;
    #2;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_addr", 32'(im_addr), 32'd0);
    chk("rst_wdata", 32'(im_wdata), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // back-to-back stream, done after 5 RUN cycles
    run_session(7, 0, 5, 1'b0);
    check_three();

    // stalled stream with cpu_done high during the load (must be ignored)
    run_session(7, 3, 5, 1'b1);
    check_three();

    // zero length
    stim[0] = 8'h00;
    run_session(1, 0, 1, 1'b0);
    chk("zl_finished", 32'(finished), 32'd1);
    chk("zl_err", 32'(err), 32'd1);
    chk("zl_cycles", 32'(cycles), 32'd0);
    chk("zl_nwr", 32'(wr_n - wb), 32'd0);
    chk("zl_no_run", 32'(run_n - ub), 32'd0);
    chk("zl_rst", 32'(rst_n - rb), 32'd0);

    // from DONE with err: one instruction, done after one cycle
    stim[0] = 8'h01; stim[1] = 8'h56; stim[2] = 8'h00;
    run_session(3, 0, 1, 1'b0);
    chk("one_err", 32'(err), 32'd0);
    chk("one_cycles", 32'(cycles), 32'd1);
    chk("one_finished", 32'(finished), 32'd1);
    chk("one_nwr", 32'(wr_n - wb), 32'd1);
    chk("one_addr", 32'(wr_a[wb]), 32'h00);
    chk("one_data", 32'(wr_d[wb]), 32'h056);

    // saturation on the 4-bit counter instance
    ub = run4_n;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid4 = 1'b1;
      in_data4  = (i == 0) ? 8'h01 : ((i == 1) ? 8'hAB : 8'h01);
      k = 0;
      @(negedge clk);
      while (!in_ready4 && k < 50) begin
        @(negedge clk);
        k++;
      end
      @(posedge clk); #1;
      in_valid4 = 1'b0;
    end
    k = 0;
    @(negedge clk);
    while (!finished4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("sat_finished", 32'(finished4), 32'd1);
    chk("sat_cycles", 32'(cycles4), 32'd15);
    chk("sat_err", 32'(err4), 32'd1);
    chk("sat_run_edges", 32'(run4_n - ub), 32'd15);
    chk("sat_addr", 32'(im_addr4), 32'h00);
    chk("sat_wdata", 32'(im_wdata4), 32'h1AB);

    // asynchronous reset mid-load, right after an instruction write
    @(posedge clk); #1;
    stim[0] = 8'h03; stim[1] = 8'h12; stim[2] = 8'h01;
    do_start();
    send_byte(8'h03);
    send_byte(8'h12);
    send_byte(8'h01);
    chk("pre_rst_we", 32'(im_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("arst_im_we", 32'(im_we), 32'd0);
    chk("arst_finished", 32'(finished), 32'd0);
    #5 reset = 1'b0;
    @(posedge clk); #1;
    stim[0] = 8'h03; stim[1] = 8'h12; stim[2] = 8'h01; stim[3] = 8'h34;
    stim[4] = 8'h00; stim[5] = 8'hFF; stim[6] = 8'h01;
    run_session(7, 0, 5, 1'b0);
    check_three();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
